// File: rtl/trace_packer_pkg.sv
// Shared definitions for the trace packer: word geometry, state encoding,
// latched configuration and slot arithmetic helpers.
package trace_packer_pkg;

  localparam int unsigned TRB_WIDTH       = 64;
  localparam int unsigned TRB_NTRACE_BITS = 2;
  localparam int unsigned POS_W           = $clog2(TRB_WIDTH);
  // Slot index must reach 2**(2**TRB_NTRACE_BITS - 1) - 1 (eight slots at n=3)
  localparam int unsigned SLOT_W          = (1 << TRB_NTRACE_BITS) - 1;
  localparam int unsigned DROP_W          = 16;

  typedef logic [TRB_WIDTH-1:0]       trb_word_t;
  typedef logic [TRB_NTRACE_BITS-1:0] ntrace_t;
  typedef logic [SLOT_W-1:0]          slot_t;
  typedef logic [POS_W-1:0]           pos_t;

  typedef enum logic [1:0] {
    ARMED     = 2'd0,
    TRIGGERED = 2'd1,
    DONE      = 2'd2
  } packer_state_t;

  typedef struct packed {
    logic    mode;
    ntrace_t ntrace;
  } packer_cfg_t;

  // Index of the last slot in a word of 2**n samples
  function automatic slot_t slot_last(input ntrace_t n);
    return SLOT_W'((32'd1 << n) - 32'd1);
  endfunction

  // Bit offset of slot k when each sample is TRB_WIDTH >> n bits wide
  function automatic pos_t slot_offset(input slot_t k, input ntrace_t n);
    return POS_W'(POS_W'(k) << (POS_W - 32'(n)));
  endfunction

  // Low-aligned mask covering one sample lane
  function automatic trb_word_t lane_mask(input ntrace_t n);
    return {TRB_WIDTH{1'b1}} >> (TRB_WIDTH - (TRB_WIDTH >> n));
  endfunction

endpackage

// File: rtl/trace_packer_if.sv
// Bus between the traced system / logger side and the trace packer.
// DROP_COUNT_O exists only when TRACE_DROP_COUNT_EN is defined.
interface trace_packer_if;
  import trace_packer_pkg::*;

  trb_word_t TRACE_I;
  logic      TRACE_VALID_I;
  logic      TRG_I;
  logic      MODE_I;
  ntrace_t   NTRACE_I;
  logic      STORE_PERM_I;
  logic      TRG_DELAYED_I;

  trb_word_t DATA_O;
  logic      STORE_O;
  pos_t      EVENT_POS_O;
  logic      TRG_EVENT_O;
  logic      OVERFLOW_O;
`ifdef TRACE_DROP_COUNT_EN
  logic [DROP_W-1:0] DROP_COUNT_O;
`endif

  // Packer side
  modport slave (
    input  TRACE_I, TRACE_VALID_I, TRG_I, MODE_I, NTRACE_I, STORE_PERM_I, TRG_DELAYED_I,
`ifdef TRACE_DROP_COUNT_EN
    output DROP_COUNT_O,
`endif
    output DATA_O, STORE_O, EVENT_POS_O, TRG_EVENT_O, OVERFLOW_O
  );

  // Feeder / logger side
  modport master (
    output TRACE_I, TRACE_VALID_I, TRG_I, MODE_I, NTRACE_I, STORE_PERM_I, TRG_DELAYED_I,
`ifdef TRACE_DROP_COUNT_EN
    input  DROP_COUNT_O,
`endif
    input  DATA_O, STORE_O, EVENT_POS_O, TRG_EVENT_O, OVERFLOW_O
  );

endinterface

// File: rtl/trace_slot_insert.sv
// Combinational lane insert: writes the low TRB_WIDTH>>n bits of a sample
// into slot k of a word, leaving the other slots untouched.
module trace_slot_insert
  import trace_packer_pkg::*;
(
  input  trb_word_t word_i,
  input  trb_word_t sample_i,
  input  slot_t     slot_i,
  input  ntrace_t   ntrace_i,
  output trb_word_t word_c
);

  trb_word_t mask;
  pos_t      off;

  // Shift the lane mask and sample into place and merge
  always_comb begin
    off    = slot_offset(slot_i, ntrace_i);
    mask   = lane_mask(ntrace_i);
    word_c = (word_i & ~(mask << off)) | ((sample_i & mask) << off);
  end

endmodule

// File: rtl/trace_packer.sv
// Trace packer: packs 1/2/4/8 trace samples per memory word, strobes each
// complete word to the logger, records the trigger position and stops once
// the logger reports the post-trigger delay has elapsed.
// Optional: TRACE_DROP_COUNT_EN adds a saturating dropped-word counter.
module trace_packer
  import trace_packer_pkg::*;
(
  input logic           CLK_I,
  input logic           RST_NI,
  trace_packer_if.slave tp
);

  packer_state_t state_q, state_d;
  slot_t         k_q, k_d;
  packer_cfg_t   cfg_q, cfg_d;
  trb_word_t     asm_q, asm_d;
  trb_word_t     data_q, data_d;
  logic          store_q, store_d;
  pos_t          pos_q, pos_d;
  logic          trg_q, trg_d;
  logic          ovf_q, ovf_d;
`ifdef TRACE_DROP_COUNT_EN
  logic [DROP_W-1:0] drop_q, drop_d;
`endif

  packer_cfg_t cfg_c;
  trb_word_t   ins_c;

  trace_slot_insert u_slot_insert (
    .word_i   (asm_q),
    .sample_i (tp.TRACE_I),
    .slot_i   (k_q),
    .ntrace_i (cfg_c.ntrace),
    .word_c   (ins_c)
  );

  // Config in force: fresh inputs at a word boundary, held copy mid-word
  always_comb begin
    cfg_c = cfg_q;
    if (k_q == '0) begin
      cfg_c.mode   = tp.MODE_I;
      cfg_c.ntrace = tp.NTRACE_I;
    end
  end

  // Next-state: packing, word completion, trigger capture and stop
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cfg_d   = cfg_c;
    asm_d   = asm_q;
    data_d  = data_q;
    store_d = 1'b0;
    pos_d   = pos_q;
    trg_d   = trg_q;
    ovf_d   = ovf_q;
`ifdef TRACE_DROP_COUNT_EN
    drop_d  = drop_q;
`endif
    case (state_q)
      ARMED, TRIGGERED: begin
        if ((state_q == TRIGGERED) && tp.TRG_DELAYED_I) begin
          // Stop: the partial (or just-completed) word is thrown away
          state_d = DONE;
          k_d     = '0;
          asm_d   = '0;
        end else if (tp.TRACE_VALID_I) begin
          asm_d = ins_c;
          if (k_q == slot_last(cfg_c.ntrace)) begin
            k_d = '0;
            if (tp.STORE_PERM_I) begin
              data_d  = ins_c;
              store_d = 1'b1;
            end else begin
              ovf_d = 1'b1;
`ifdef TRACE_DROP_COUNT_EN
              if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
`endif
            end
          end else begin
            k_d = k_q + slot_t'(1);
          end
          if ((state_q == ARMED) && !cfg_c.mode && tp.TRG_I) begin
            trg_d   = 1'b1;
            pos_d   = slot_offset(k_q, cfg_c.ntrace);
            state_d = TRIGGERED;
          end
        end
      end
      default: ;
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q <= ARMED;
      k_q     <= '0;
      cfg_q   <= '0;
      asm_q   <= '0;
      data_q  <= '0;
      store_q <= 1'b0;
      pos_q   <= '0;
      trg_q   <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef TRACE_DROP_COUNT_EN
      drop_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cfg_q   <= cfg_d;
      asm_q   <= asm_d;
      data_q  <= data_d;
      store_q <= store_d;
      pos_q   <= pos_d;
      trg_q   <= trg_d;
      ovf_q   <= ovf_d;
`ifdef TRACE_DROP_COUNT_EN
      drop_q  <= drop_d;
`endif
    end
  end

  assign tp.DATA_O      = data_q;
  assign tp.STORE_O     = store_q;
  assign tp.EVENT_POS_O = pos_q;
  assign tp.TRG_EVENT_O = trg_q;
  assign tp.OVERFLOW_O  = ovf_q;
`ifdef TRACE_DROP_COUNT_EN
  assign tp.DROP_COUNT_O = drop_q;
`endif

endmodule

// File: tb/tb_trace_packer.sv
// Bench for trace_packer: per-cycle vector tables with expected sticky
// outputs, plus a scoreboard of expected stored words and their cycles.
module tb_trace_packer;
  import trace_packer_pkg::*;

  typedef struct {
    ntrace_t     nt;
    logic        mode;
    logic        valid;
    trb_word_t   smp;
    logic        trg;
    logic        perm;
    logic        dly;
    logic        push;
    trb_word_t   word;
    logic        e_trg;
    pos_t        e_pos;
    logic        e_ovf;
    logic [15:0] e_drop;
  } vec_t;

  typedef struct {
    trb_word_t word;
    int        cyc;
  } exp_t;

  logic CLK_I  = 1'b0;
  logic RST_NI = 1'b0;

  trace_packer_if tp();

  trace_packer dut (
    .CLK_I  (CLK_I),
    .RST_NI (RST_NI),
    .tp     (tp)
  );

  always #5 CLK_I = ~CLK_I;

  int cyc = 0;
  always @(posedge CLK_I) cyc <= cyc + 1;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  vec_t        tbl[$];
  exp_t        sb[$];

  ntrace_t     cur_nt   = '0;
  logic        cur_mode = 1'b0;
  logic        x_trg    = 1'b0;
  pos_t        x_pos    = '0;
  logic        x_ovf    = 1'b0;
  logic [15:0] x_drop   = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic idle();
    tp.TRACE_I       = '0;
    tp.TRACE_VALID_I = 1'b0;
    tp.TRG_I         = 1'b0;
    tp.MODE_I        = cur_mode;
    tp.NTRACE_I      = cur_nt;
    tp.STORE_PERM_I  = 1'b1;
    tp.TRG_DELAYED_I = 1'b0;
  endtask

  task automatic clear_x();
    x_trg = 1'b0; x_pos = '0; x_ovf = 1'b0; x_drop = '0;
  endtask

  task automatic add(input logic valid, input trb_word_t smp, input logic trg,
                     input logic perm, input logic dly, input logic push, input trb_word_t word);
    vec_t v;
    v.nt = cur_nt; v.mode = cur_mode; v.valid = valid; v.smp = smp; v.trg = trg;
    v.perm = perm; v.dly = dly; v.push = push; v.word = word;
    v.e_trg = x_trg; v.e_pos = x_pos; v.e_ovf = x_ovf; v.e_drop = x_drop;
    tbl.push_back(v);
  endtask

  task automatic add_idle();
    add(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
  endtask

  // Apply one vector per cycle (driven on the falling edge) and check sticky outputs
  task automatic run_tbl(input string tag);
    foreach (tbl[i]) begin
      tp.NTRACE_I      = tbl[i].nt;
      tp.MODE_I        = tbl[i].mode;
      tp.TRACE_VALID_I = tbl[i].valid;
      tp.TRACE_I       = tbl[i].smp;
      tp.TRG_I         = tbl[i].trg;
      tp.STORE_PERM_I  = tbl[i].perm;
      tp.TRG_DELAYED_I = tbl[i].dly;
      if (tbl[i].push) sb.push_back('{word: tbl[i].word, cyc: cyc + 1});
      @(negedge CLK_I);
      chk($sformatf("%s_v%0d_trg_event", tag, i), 64'(tp.TRG_EVENT_O), 64'(tbl[i].e_trg));
      chk($sformatf("%s_v%0d_event_pos", tag, i), 64'(tp.EVENT_POS_O), 64'(tbl[i].e_pos));
      chk($sformatf("%s_v%0d_overflow", tag, i), 64'(tp.OVERFLOW_O), 64'(tbl[i].e_ovf));
`ifdef TRACE_DROP_COUNT_EN
      chk($sformatf("%s_v%0d_drop_count", tag, i), 64'(tp.DROP_COUNT_O), 64'(tbl[i].e_drop));
`endif
    end
    tbl.delete();
    idle();
  endtask

  task automatic do_reset();
    RST_NI = 1'b0;
    idle();
    repeat (2) @(negedge CLK_I);
    RST_NI = 1'b1;
    clear_x();
    @(negedge CLK_I);
  endtask

  // Store monitor: every strobe must match the oldest expected word and cycle
  always @(negedge CLK_I) begin
    if (RST_NI) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        exp_t e;
        e = sb.pop_front();
        chk("store_missing_cycle", 64'(cyc), 64'(e.cyc));
      end
      if (tp.STORE_O) begin
        if (sb.size() == 0) begin
          chk("store_unexpected", 64'(tp.STORE_O), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("store_data", tp.DATA_O, e.word);
          chk("store_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  initial begin
    idle();
    RST_NI = 1'b0;
    repeat (2) @(negedge CLK_I);
    chk("reset_data", tp.DATA_O, 64'd0);
    chk("reset_store", 64'(tp.STORE_O), 64'd0);
    chk("reset_pos", 64'(tp.EVENT_POS_O), 64'd0);
    chk("reset_trg_event", 64'(tp.TRG_EVENT_O), 64'd0);
    chk("reset_overflow", 64'(tp.OVERFLOW_O), 64'd0);
    RST_NI = 1'b1;
    @(negedge CLK_I);

    // Four 16-bit samples per word; upper input bits are junk and must be ignored
    cur_nt = 2'd2;
    add_idle();
    add(1, 64'hFEDC_BA98_7654_1111, 0, 1, 0, 0, '0);
    add(1, 64'h0F0F_0F0F_0F0F_2222, 0, 1, 0, 0, '0);
    add(1, 64'hFFFF_FFFF_FFFF_3333, 0, 1, 0, 0, '0);
    add(1, 64'h1234_5678_9ABC_4444, 0, 1, 0, 1, 64'h4444_3333_2222_1111);
    add_idle();
    add_idle();
    run_tbl("pack4");
    chk("data_hold", tp.DATA_O, 64'h4444_3333_2222_1111);
    chk("store_low_after_word", 64'(tp.STORE_O), 64'd0);

    // One sample per word, back-to-back strobes
    cur_nt = 2'd0;
    add_idle();
    add(1, 64'h0123_4567_89AB_CDEF, 0, 1, 0, 1, 64'h0123_4567_89AB_CDEF);
    add(1, 64'hFEDC_BA98_7654_3210, 0, 1, 0, 1, 64'hFEDC_BA98_7654_3210);
    add(1, 64'hA5A5_5A5A_0F0F_F0F0, 0, 1, 0, 1, 64'hA5A5_5A5A_0F0F_F0F0);
    add_idle();
    run_tbl("b2b");

    // Drop a word, then the next one lands with correct alignment
    cur_nt = 2'd1;
    add_idle();
    add(1, {32'hDEAD_BEEF, 32'hAAAA_0001}, 0, 1, 0, 0, '0);
    x_ovf = 1'b1; x_drop = 16'd1;
    add(1, {32'hDEAD_BEEF, 32'hAAAA_0002}, 0, 0, 0, 0, '0);
    add(1, {32'hDEAD_BEEF, 32'hBBBB_0003}, 0, 0, 0, 0, '0);
    add(1, {32'hDEAD_BEEF, 32'hBBBB_0004}, 0, 1, 0, 1, 64'hBBBB_0004_BBBB_0003);
    add_idle();
    run_tbl("drop");

    // Streaming mode ignores triggers and keeps packing
    cur_mode = 1'b1; cur_nt = 2'd2;
    add_idle();
    for (int i = 0; i < 4; i++)
      add(1, {48'h5A5A_5A5A_5A5A, 16'(16'h0101 * (i + 1))}, 1, 1, 0, i == 3, 64'h0404_0303_0202_0101);
    add_idle();
    cur_mode = 1'b0;
    add_idle();
    run_tbl("stream");

    // Trigger on the third of eight samples, then stop on a completing word
    cur_nt = 2'd3;
    add_idle();
    add(0, '0, 1, 1, 0, 0, '0);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin x_trg = 1'b1; x_pos = 6'd16; end
      add(1, {56'hC3C3_C3C3_C3C3_C3, 8'(8'h11 * (i + 1))}, i == 2, 1, i == 0, i == 7, 64'h8877_6655_4433_2211);
    end
    for (int i = 0; i < 8; i++)
      add(1, {56'h3C3C_3C3C_3C3C_3C, 8'(8'h91 + i)}, i == 5, 1, i == 7, 0, '0);
    for (int i = 0; i < 8; i++)
      add(1, 64'($urandom()), 1, 1, 0, 0, '0);
    add_idle();
    run_tbl("trig");

    // Async reset mid-word with every output non-zero
    do_reset();
    cur_nt = 2'd2;
    add_idle();
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin x_trg = 1'b1; x_pos = 6'd16; end
      if (i == 3) begin x_ovf = 1'b1; x_drop = 16'd1; end
      add(1, {48'hF00D_F00D_F00D, 16'(16'h0A01 + i)}, i == 1, i != 3, 0, 0, '0);
    end
    for (int i = 0; i < 4; i++)
      add(1, {48'hF00D_F00D_F00D, 16'(16'h0B01 + i)}, 0, 1, 0, i == 3, 64'h0B04_0B03_0B02_0B01);
    add(1, 64'h0000_0000_0000_0C01, 0, 1, 0, 0, '0);
    add(1, 64'h0000_0000_0000_0C02, 0, 1, 0, 0, '0);
    run_tbl("pre_areset");
    #2 RST_NI = 1'b0;
    #1;
    chk("areset_data", tp.DATA_O, 64'd0);
    chk("areset_store", 64'(tp.STORE_O), 64'd0);
    chk("areset_pos", 64'(tp.EVENT_POS_O), 64'd0);
    chk("areset_trg_event", 64'(tp.TRG_EVENT_O), 64'd0);
    chk("areset_overflow", 64'(tp.OVERFLOW_O), 64'd0);
`ifdef TRACE_DROP_COUNT_EN
    chk("areset_drop_count", 64'(tp.DROP_COUNT_O), 64'd0);
`endif
    @(negedge CLK_I);
    RST_NI = 1'b1;
    clear_x();

    // Fresh word after reset: no stale slots, alignment restarts at slot 0
    add_idle();
    add(1, 64'h0000_0000_0000_5555, 0, 1, 0, 0, '0);
    add(1, 64'h0000_0000_0000_6666, 0, 1, 0, 0, '0);
    add(1, 64'h0000_0000_0000_7777, 0, 1, 0, 0, '0);
    add(1, 64'h0000_0000_0000_8888, 0, 1, 0, 1, 64'h8888_7777_6666_5555);
    add_idle();
    add_idle();
    run_tbl("post_areset");

    repeat (3) @(negedge CLK_I);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
